spi_slave_cu: RTL

- SPI slave (responder) that sits at the far end of the bus from the team's SPI master control unit; supports all four CPol/CPha modes.
- Oversamples SCK, SS_n and MOSI in the system Clk domain.
- Shifts a DATA_W-bit word in on MOSI and out on MISO, with a one-entry transmit holding buffer and a one-cycle receive-valid pulse toward the register file.
- Supports back-to-back words while SS_n stays low.

---
 rtl/spi_slave_cu.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_cu.sv
//============================================================================
// spi_slave_cu : oversampled SPI slave, all four CPol/CPha modes, 1-word tx buffer.
// Optional macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first transfer.  Rev 1.0
//============================================================================
`default_nettype none

module spi_slave_cu #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              CPol,
  input  logic              CPha,
  input  logic              SCK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxLoad,
  output logic              TxReady,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  output logic              Underrun,
  output logic              Busy
);

  localparam int              CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_pipe, ss_pipe, mosi_pipe;
  logic                   sck_s, ss_s, mosi_s, sck_prev, ss_prev;
  logic                   cpol_q, cpha_q;
  logic                   lead_edge, trail_edge, sample_edge, change_edge, ss_fall;
  logic                   word_load;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      tx_shift, rx_shift, hold_data, rx_data;
  logic [DATA_W-1:0]      rx_next, tx_next;
  logic                   hold_full, rx_valid, underrun, tx_bit;

  // SS_n resets to its inactive level so reset release cannot fake a select.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sck_pipe  <= '0;
      ss_pipe   <= '1;
      mosi_pipe <= '0;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], SCK};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], SS_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
      sck_prev  <= sck_s;
      ss_prev   <= ss_s;
    end
  end

  assign sck_s       = sck_pipe[SYNC_STAGES-1];
  assign ss_s        = ss_pipe[SYNC_STAGES-1];
  assign mosi_s      = mosi_pipe[SYNC_STAGES-1];
  assign lead_edge   = (sck_s != sck_prev) && (sck_s != cpol_q);
  assign trail_edge  = (sck_s != sck_prev) && (sck_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign change_edge = cpha_q ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev && !ss_s;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next = {mosi_s, rx_shift[DATA_W-1:1]};
  assign tx_next = {1'b0, tx_shift[DATA_W-1:1]};
  assign tx_bit  = tx_shift[0];
`else
  assign rx_next = {rx_shift[DATA_W-2:0], mosi_s};
  assign tx_next = {tx_shift[DATA_W-2:0], 1'b0};
  assign tx_bit  = tx_shift[DATA_W-1];
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    word_load = 1'b0;
    Busy      = 1'b0;
    MISO_oe   = 1'b0;
    MISO      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
          word_load = 1'b1;
        end
      end
      SHIFT: begin
        Busy    = 1'b1;
        MISO_oe = 1'b1;
        MISO    = tx_bit;
        if (ss_s)
          state_nxt = IDLE;
        else if (change_edge && bit_cnt == CNT_FULL)
          word_load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      if (state == IDLE) begin
        cpol_q <= CPol;
        cpha_q <= CPha;
      end

      // A load that finds the buffer empty still accepts a same-cycle TxLoad.
      if (TxLoad && !hold_full) begin
        hold_data <= TxData;
        hold_full <= 1'b1;
      end else if (word_load && hold_full) begin
        hold_full <= 1'b0;
      end

      if (word_load) begin
        if (hold_full) tx_shift <= hold_data;
        else begin
          tx_shift <= '1;
          underrun <= 1'b1;
        end
      end

      if (state == IDLE || ss_s) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + CNT_ONE;
        if (bit_cnt == CNT_FULL - CNT_ONE) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end else if (change_edge) begin
        if (bit_cnt == CNT_FULL)  bit_cnt  <= '0;
        else if (bit_cnt != '0)   tx_shift <= tx_next;
      end
    end
  end

  assign TxReady  = !hold_full;
  assign RxData   = rx_data;
  assign RxValid  = rx_valid;
  assign Underrun = underrun;

endmodule

`default_nettype wire
